// File: rtl/nibbler_bus_pkg.sv
// Purpose: shared types, widths and helpers for the Nibbler data-RAM bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibbler_bus_pkg;

  // Default geometry of the Nibbler data RAM: 4096 nibbles.
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  // Access sequencer state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    STROBE = ST_STROBE,
    HOLD   = ST_HOLD
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold a down-counter that starts at n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_bus_tristate.sv
// Purpose: the only place that drives Z on the shared RAM data bus.
// Latency: combinational pad driver and pad sampler.
// Backpressure: none; oe comes straight from a register in the sequencer.
module ram_bus_tristate
  import nibbler_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] wdata,
  inout  wire  [DATA_W-1:0] pad,
  output logic [DATA_W-1:0] rdata
);

  // Drive the pad only when enabled, otherwise release it for the RAM.
  assign pad   = oe ? wdata : {DATA_W{1'bz}};

  // Whatever is on the pad is visible to the sequencer for read sampling.
  assign rdata = pad;

endmodule

// File: rtl/ram_bus_master.sv
// Purpose: single-request bus initiator for the Nibbler 4-bit data RAM (setup/strobe/hold sequencing).
// Latency: rsp_valid SETUP_CYC+ACCESS_CYC+1 cycles after accept; req_ready back one cycle later.
// Backpressure: req_ready is high only in IDLE; req_valid outside IDLE is ignored, never queued.
module ram_bus_master
  import nibbler_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_we,
  output logic              ram_cs,
  inout  wire  [DATA_W-1:0] ram_data
);

  // The phase counter only ever holds (phase length - 1) and is reloaded on
  // every state entry, so it is sized to the longer of the two phases.
  localparam int CNT_MAX = max_int(SETUP_CYC, ACCESS_CYC);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYC - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Latched write data and the bus output enable; oe_q mirrors the latched
  // write flag so the master never drives while the RAM is reading out.
  logic               oe_q;
  logic               oe_d;
  logic [DATA_W-1:0]  wdat_q;
  logic [DATA_W-1:0]  wdat_d;

  // Next values of the registered outputs.
  logic [ADDR_W-1:0]  add_d;
  logic               we_d;
  logic               cs_d;
  logic               rsp_vld_d;
  logic [DATA_W-1:0]  rdat_d;
  logic               rdy_d;
  logic               busy_d;

  logic [DATA_W-1:0]  bus_rdat;

  ram_bus_tristate #(
    .DATA_W (DATA_W)
  ) u_tristate (
    .oe    (oe_q),
    .wdata (wdat_q),
    .pad   (ram_data),
    .rdata (bus_rdat)
  );

  // State and phase counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_d     = ram_add;
    we_d      = ram_we;
    cs_d      = 1'b0;
    oe_d      = oe_q;
    wdat_d    = wdat_q;
    rsp_vld_d = 1'b0;
    rdat_d    = rsp_rdata;
    rdy_d     = req_ready;
    busy_d    = busy;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          add_d   = req_addr;
          we_d    = req_we;
          oe_d    = req_we;
          wdat_d  = req_wdata;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SETUP: begin
        cs_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = ACCESS_LOAD;
          cs_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: the RAM is still driving, so sample here.
          state_d   = HOLD;
          cnt_d     = '0;
          rsp_vld_d = 1'b1;
          if (!ram_we) begin
            rdat_d = bus_rdat;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          cs_d  = 1'b1;
        end
      end

      HOLD: begin
        state_d = IDLE;
        cnt_d   = '0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_add   <= '0;
      ram_we    <= 1'b0;
      ram_cs    <= 1'b0;
      oe_q      <= 1'b0;
      wdat_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      ram_add   <= add_d;
      ram_we    <= we_d;
      ram_cs    <= cs_d;
      oe_q      <= oe_d;
      wdat_q    <= wdat_d;
      rsp_valid <= rsp_vld_d;
      rsp_rdata <= rdat_d;
      req_ready <= rdy_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Purpose: self-checking bench for ram_bus_master with two timing configurations and RAM models.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_bus_master;

  localparam int S0 = 1;
  localparam int A0 = 1;
  localparam int S1 = 2;
  localparam int A1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [11:0] req_addr;
  logic [3:0]  req_wdata;

  logic        req_valid0;
  logic        req_valid1;
  logic        rdy0, rsp0, busy0, we0, cs0;
  logic        rdy1, rsp1, busy1, we1, cs1;
  logic [3:0]  rdata0, rdata1;
  logic [11:0] add0, add1;
  wire  [3:0]  bus0;
  wire  [3:0]  bus1;

  logic        s_rdy, s_rsp, s_cs;
  logic [3:0]  s_rdata;
  logic [11:0] s_add;

  logic        mem_clr;
  logic        probe_en;
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [3:0]  pre_dat;

  logic [3:0]  mem0 [4096];
  logic [3:0]  mem1 [4096];
  logic [3:0]  exp0 [4096];
  logic [3:0]  exp1 [4096];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req_valid0 = req_valid && !sel;
  assign req_valid1 = req_valid && sel;

  assign s_rdy   = sel ? rdy1   : rdy0;
  assign s_rsp   = sel ? rsp1   : rsp0;
  assign s_rdata = sel ? rdata1 : rdata0;
  assign s_add   = sel ? add1   : add0;
  assign s_cs    = sel ? cs1    : cs0;

  ram_bus_master dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp0), .rsp_rdata(rdata0), .busy(busy0),
    .ram_add(add0), .ram_we(we0), .ram_cs(cs0), .ram_data(bus0)
  );

  ram_bus_master #(.SETUP_CYC(S1), .ACCESS_CYC(A1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp1), .rsp_rdata(rdata1), .busy(busy1),
    .ram_add(add1), .ram_we(we1), .ram_cs(cs1), .ram_data(bus1)
  );

  // Asynchronous RAM models: drive read data while selected for read.
  // probe_en weakly-idles bus0 at 0 so a released master bus reads back 0.
  assign bus0 = (cs0 && !we0) ? mem0[add0] : (probe_en ? 4'h0 : 4'hz);
  assign bus1 = (cs1 && !we1) ? mem1[add1] : 4'hz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem0[i] <= 4'h0;
    end else if (cs0 && we0) begin
      mem0[add0] <= bus0;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= 4'h0;
    end else begin
      if (pre_en) mem1[pre_addr] <= pre_dat;
      if (cs1 && we1) mem1[add1] <= bus1;
    end
  end

  // Bus safety invariants, sampled every cycle away from the clock edge.
  logic        pcs0 = 1'b0, pwe0 = 1'b0, pcs1 = 1'b0, pwe1 = 1'b0;
  logic [11:0] padd0 = '0, padd1 = '0;
  always @(negedge clk) begin
    if (reset) begin
      pcs0 = 1'b0;
      pcs1 = 1'b0;
    end else begin
      n_vec++;
      if (dut0.oe_q && cs0 && !we0) begin
        n_err++; $display("FAIL contention0 oe=%0b cs=%0b we=%0b required oe=0", dut0.oe_q, cs0, we0);
      end
      n_vec++;
      if (dut1.oe_q && cs1 && !we1) begin
        n_err++; $display("FAIL contention1 oe=%0b cs=%0b we=%0b required oe=0", dut1.oe_q, cs1, we1);
      end
      if (pcs0 || cs0) begin
        n_vec++;
        if (we0 !== pwe0 || add0 !== padd0) begin
          n_err++; $display("FAIL cs_stable0 we=%0b add=%h required we=%0b add=%h", we0, add0, pwe0, padd0);
        end
      end
      if (pcs1 || cs1) begin
        n_vec++;
        if (we1 !== pwe1 || add1 !== padd1) begin
          n_err++; $display("FAIL cs_stable1 we=%0b add=%h required we=%0b add=%h", we1, add1, pwe1, padd1);
        end
      end
      pcs0 = cs0; pwe0 = we0; padd0 = add0;
      pcs1 = cs1; pwe1 = we1; padd1 = add1;
    end
  end

  // Issue one request and observe it until req_ready returns.
  // Cycle k counts negedges after the accepting rising edge.
  task automatic run_access(input bit s, input bit we, input logic [11:0] a, input logic [3:0] d,
                            input bit hold_valid, output int lat, output int cs_cyc,
                            output int rdy_at, output int rsp_cnt, output int add_bad,
                            output logic [3:0] rd);
    @(negedge clk);
    sel = s; req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = 1'b0;
    lat = -1; cs_cyc = 0; rdy_at = -1; rsp_cnt = 0; add_bad = 0; rd = 4'h0;
    for (int k = 1; k <= 40 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (s_cs) cs_cyc++;
      if (s_rsp) begin
        rsp_cnt++;
        if (lat < 0) begin lat = k; rd = s_rdata; end
      end
      if (s_add !== a) add_bad++;
      if (s_rdy) begin
        rdy_at = k;
        req_valid = 1'b0;
      end else if (hold_valid) begin
        req_we = 1'($urandom);
        req_addr = 12'($urandom);
        req_wdata = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_clr = 1'b1; probe_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin exp0[i] = 4'h0; exp1[i] = 4'h0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    n_vec++;
    if ({rdy0, busy0, rsp0, rdata0, add0, we0, cs0} !== {1'b1, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_dut0 rdy=%0b busy=%0b rsp=%0b rd=%h add=%h we=%0b cs=%0b required 1 0 0 0 000 0 0",
                        rdy0, busy0, rsp0, rdata0, add0, we0, cs0);
    end
    n_vec++;
    if ({rdy1, busy1, rsp1, rdata1, add1, we1, cs1} !== {1'b1, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_dut1 rdy=%0b busy=%0b rsp=%0b rd=%h add=%h we=%0b cs=%0b required 1 0 0 0 000 0 0",
                        rdy1, busy1, rsp1, rdata1, add1, we1, cs1);
    end
    n_vec++;
    if (bus0 !== 4'h0) begin
      n_err++; $display("FAIL reset_bus_released bus=%h required 0 (probe)", bus0);
    end
    #2 reset = 1'b0; probe_en = 1'b0;
  endtask

  task automatic test_write_read;
    int lat, csc, rat, rc, ab;
    logic [3:0] rd;
    run_access(1'b0, 1'b1, 12'h0A5, 4'h9, 1'b0, lat, csc, rat, rc, ab, rd);
    exp0[12'h0A5] = 4'h9;
    n_vec++;
    if (lat != S0 + A0 + 1 || csc != A0 || rc != 1 || rat != S0 + A0 + 2) begin
      n_err++; $display("FAIL wr_0a5_timing lat=%0d cs=%0d rsp=%0d rdy=%0d required %0d %0d 1 %0d",
                        lat, csc, rc, rat, S0 + A0 + 1, A0, S0 + A0 + 2);
    end
    run_access(1'b0, 1'b0, 12'h0A5, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    n_vec++;
    if (lat != S0 + A0 + 1 || csc != A0 || rc != 1) begin
      n_err++; $display("FAIL rd_0a5_timing lat=%0d cs=%0d rsp=%0d required %0d %0d 1", lat, csc, rc, S0 + A0 + 1, A0);
    end
    n_vec++;
    if (rd !== 4'h9) begin
      n_err++; $display("FAIL rd_0a5_data got=%h required 9", rd);
    end
  endtask

  task automatic test_range_ends;
    int lat, csc, rat, rc, ab;
    logic [3:0] rd;
    run_access(1'b0, 1'b1, 12'hFFF, 4'h3, 1'b0, lat, csc, rat, rc, ab, rd);
    exp0[12'hFFF] = 4'h3;
    run_access(1'b0, 1'b1, 12'h000, 4'hC, 1'b0, lat, csc, rat, rc, ab, rd);
    exp0[12'h000] = 4'hC;
    run_access(1'b0, 1'b0, 12'hFFF, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    n_vec++;
    if (rd !== 4'h3) begin
      n_err++; $display("FAIL rd_fff got=%h required 3", rd);
    end
    run_access(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    n_vec++;
    if (rd !== 4'hC) begin
      n_err++; $display("FAIL rd_000 got=%h required c", rd);
    end
  endtask

  task automatic test_slow_timing;
    int lat, csc, rat, rc, ab;
    logic [3:0] rd;
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 12'h123; pre_dat = 4'h7;
    @(posedge clk);
    #1 pre_en = 1'b0;
    exp1[12'h123] = 4'h7;
    run_access(1'b1, 1'b0, 12'h123, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    n_vec++;
    if (lat != S1 + A1 + 1 || csc != A1 || rc != 1 || rat != S1 + A1 + 2) begin
      n_err++; $display("FAIL slow_rd_timing lat=%0d cs=%0d rsp=%0d rdy=%0d required %0d %0d 1 %0d",
                        lat, csc, rc, rat, S1 + A1 + 1, A1, S1 + A1 + 2);
    end
    n_vec++;
    if (rd !== 4'h7) begin
      n_err++; $display("FAIL slow_rd_data got=%h required 7", rd);
    end
    run_access(1'b1, 1'b1, 12'h456, 4'hB, 1'b0, lat, csc, rat, rc, ab, rd);
    exp1[12'h456] = 4'hB;
    run_access(1'b1, 1'b0, 12'h456, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    n_vec++;
    if (rd !== exp1[12'h456] || lat != S1 + A1 + 1) begin
      n_err++; $display("FAIL slow_wr_rd got=%h lat=%0d required %h %0d", rd, lat, exp1[12'h456], S1 + A1 + 1);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, csc, rat, rc, ab;
    int extra_cs;
    logic [3:0] rd;
    run_access(1'b0, 1'b1, 12'h2B4, 4'h6, 1'b1, lat, csc, rat, rc, ab, rd);
    exp0[12'h2B4] = 4'h6;
    n_vec++;
    if (rat != S0 + A0 + 2 || rc != 1 || csc != A0 || ab != 0) begin
      n_err++; $display("FAIL busy_single rdy=%0d rsp=%0d cs=%0d addr_changes=%0d required %0d 1 %0d 0",
                        rat, rc, csc, ab, S0 + A0 + 2, A0);
    end
    extra_cs = 0;
    repeat (5) begin
      @(negedge clk);
      if (cs0) extra_cs++;
    end
    n_vec++;
    if (extra_cs != 0) begin
      n_err++; $display("FAIL busy_no_second_access cs_cycles=%0d required 0", extra_cs);
    end
    n_vec++;
    if (mem0[12'h2B4] !== 4'h6) begin
      n_err++; $display("FAIL busy_ram_content got=%h required 6", mem0[12'h2B4]);
    end
  endtask

  task automatic test_reset_mid_strobe;
    int waited;
    int stray_rsp;
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_addr = 12'h3C3; req_wdata = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waited = 0;
    while (!cs0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!cs0) begin
      n_err++; $display("FAIL rst_strobe_reached cs=%0b required 1", cs0);
    end
    #2 reset = 1'b1; probe_en = 1'b1;
    #1;
    n_vec++;
    if (cs0 !== 1'b0 || we0 !== 1'b0 || bus0 !== 4'h0 || rsp0 !== 1'b0) begin
      n_err++; $display("FAIL rst_immediate cs=%0b we=%0b bus=%h rsp=%0b required 0 0 0(released) 0",
                        cs0, we0, bus0, rsp0);
    end
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0; probe_en = 1'b0;
    stray_rsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0 || cs0) stray_rsp++;
    end
    n_vec++;
    if (stray_rsp != 0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      n_err++; $display("FAIL rst_after stray=%0d rdy=%0b busy=%0b required 0 1 0", stray_rsp, rdy0, busy0);
    end
  endtask

  task automatic test_random;
    int lat, csc, rat, rc, ab;
    int bad_lat, bad_rd, bad_hold, bad_mem;
    logic [3:0] rd, last_rd, d;
    logic [11:0] a;
    bit we;
    run_access(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, lat, csc, rat, rc, ab, rd);
    last_rd = exp0[12'h000];
    bad_lat = 0; bad_rd = 0; bad_hold = 0;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       a = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'hFFF;
        1:       a = 12'($urandom_range(0, 15));
        default: a = 12'($urandom);
      endcase
      we = 1'($urandom);
      d  = 4'($urandom);
      run_access(1'b0, we, a, d, 1'b0, lat, csc, rat, rc, ab, rd);
      if (lat != S0 + A0 + 1 || csc != A0 || rc != 1 || rat != S0 + A0 + 2) bad_lat++;
      if (we) begin
        exp0[a] = d;
        if (rd !== last_rd) bad_hold++;
      end else begin
        if (rd !== exp0[a]) begin
          bad_rd++;
          $display("FAIL rand_read addr=%h got=%h required %h", a, rd, exp0[a]);
        end
        last_rd = exp0[a];
      end
    end
    n_vec++;
    if (bad_lat != 0) begin
      n_err++; $display("FAIL rand_timing bad_accesses=%0d required 0", bad_lat);
    end
    n_vec++;
    if (bad_rd != 0) begin
      n_err++; $display("FAIL rand_reads bad_reads=%0d required 0", bad_rd);
    end
    n_vec++;
    if (bad_hold != 0) begin
      n_err++; $display("FAIL rand_rdata_hold bad_writes=%0d required 0", bad_hold);
    end
    bad_mem = 0;
    for (int i = 0; i < 4096; i++) if (mem0[i] !== exp0[i]) bad_mem++;
    n_vec++;
    if (bad_mem != 0) begin
      n_err++; $display("FAIL rand_ram_image bad_locations=%0d required 0", bad_mem);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
    probe_en = 1'b0; mem_clr = 1'b0; reset = 1'b1;
    test_reset();
    test_write_read();
    test_range_ends();
    test_slow_timing();
    test_busy_ignore();
    test_reset_mid_strobe();
    test_random();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
